multiword_add_seq: RTL and testbench
====================================

MULTIWORD_ADD_SEQ -- requirements
Module: multiword_add_seq

Interface
REQ-001 SHALL have parameter NWORDS, default 4, number of 64-bit words per operand (legal 2..8).
REQ-002 SHALL have port clk  in  1  clock, all state on rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have port req_valid  in  1  request offered.
REQ-005 SHALL have port req_ready  out  1  block can accept a request.
REQ-006 SHALL have port op_a  in  64*NWORDS  addend A, word 0 = bits [63:0].
REQ-007 SHALL have port op_b  in  64*NWORDS  addend B.
REQ-008 SHALL have port cin  in  1  initial carry-in.
REQ-009 SHALL have port op_sub  in  1  subtract select (present only with MWADD_SUB_EN).
REQ-010 SHALL have port rsp_valid  out  1  result available.
REQ-011 SHALL have port rsp_ready  in  1  consumer takes result.
REQ-012 SHALL have port rsp_sum  out  64*NWORDS  result.
REQ-013 SHALL have port rsp_cout  out  1  final carry out of word NWORDS-1.

Function
REQ-014 SHALL implement FSM IDLE -> ADD -> DONE -> IDLE.
REQ-015 SHALL assert req_ready only in IDLE; a request is accepted on a rising edge with req_valid && req_ready.
REQ-016 On accept, SHALL latch op_a, op_b, cin (and op_sub), clear word counter, set carry register = cin, and enter ADD.
REQ-017 In ADD, SHALL add exactly one 64-bit word per cycle through one shared 64-bit CLA: word i of A, word i of B, carry register; sum written to word i of rsp_sum register, carry register <= adder cout.
REQ-018 After word NWORDS-1, SHALL enter DONE with rsp_cout = final carry; rsp_valid high exactly NWORDS cycles after the accept edge.
REQ-019 SHALL hold rsp_valid, rsp_sum and rsp_cout stable while rsp_valid && !rsp_ready.
REQ-020 DONE with rsp_ready high SHALL return to IDLE on that edge, so req_ready is high the next cycle; no request is accepted in the handshake cycle.
REQ-021 Input changes outside the accept edge SHALL have no effect on an in-flight operation.
REQ-022 Counter SHALL be ceil(log2(NWORDS)) bits and SHALL never wrap past NWORDS-1.

Reset
REQ-023 rst SHALL force IDLE immediately, including mid-ADD or in DONE, discarding the operation.
REQ-024 During and after reset: req_ready=1, rsp_valid=0, rsp_sum=0, rsp_cout=0, counter=0, carry register=0.

Configuration
REQ-025 With MWADD_SUB_EN defined, op_sub=1 SHALL use ~op_b with initial carry forced to 1 (cin ignored); rsp_cout=1 means no borrow (A >= B).
REQ-026 Without MWADD_SUB_EN, port op_sub and its latch SHALL be absent and only addition is performed.

Structure
REQ-027 Shared package SHALL hold the FSM state encoding (IDLE, ADD, DONE), WORD_W = 64, and the default NWORDS.
REQ-028 The 64-bit adder SHALL be one instance of the existing CLA_64bit sub-module; its group-propagate and group-generate outputs stay unused.

Verification
REQ-029 NWORDS=4, A=2^256-1, B=0, cin=1 -> rsp_sum=0, rsp_cout=1, rsp_valid exactly 4 cycles after accept.
REQ-030 A=2^64-1, B=1, cin=0 -> rsp_sum=2^64 (word1=1, others 0), rsp_cout=0, proving cross-word carry.
REQ-031 Hold rsp_ready=0 for 5 cycles in DONE -> outputs stable and req_ready=0; raise rsp_ready -> req_ready=1 next cycle.
REQ-032 Assert rst during word 2 of ADD -> rsp_valid=0 and rsp_sum=0 at once, req_ready=1; next request A=3, B=4 -> 7.
REQ-033 MWADD_SUB_EN, op_sub=1, A=5, B=7 -> rsp_sum=2^256-2, rsp_cout=0; A=7, B=5 -> 2, rsp_cout=1.
REQ-034 Run 100 random A/B/cin with random rsp_ready stalls; every {rsp_cout, rsp_sum} must equal the 257-bit golden A+B+cin.

Source files
------------

// File: rtl/multiword_add_seq_pkg.sv
// Shared definitions for the sequential multi-word adder: FSM encoding, word width and
// the 4-bit propagate/generate helper used by the CLA.
package multiword_add_seq_pkg;

  localparam int unsigned WORD_W     = 64;
  localparam int unsigned NWORDS_DEF = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADD  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef logic [WORD_W-1:0] word_t;

  function automatic int unsigned cnt_width(input int unsigned nwords);
    return (nwords < 2) ? 1 : $clog2(nwords);
  endfunction

  // Returns {group propagate, group generate} for a 4-wide slice.
  function automatic logic [1:0] pg4(input logic [3:0] p, input logic [3:0] g);
    logic gen;
    gen = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    return {&p, gen};
  endfunction

endpackage

// File: rtl/multiword_add_seq_if.sv
// Request/response bundle for multiword_add_seq; op_sub exists only when MWADD_SUB_EN is
// defined.
interface multiword_add_seq_if
  import multiword_add_seq_pkg::*;
#(
  parameter int unsigned NWORDS = NWORDS_DEF
) ();

  logic                     req_valid;
  logic                     req_ready;
  logic [WORD_W*NWORDS-1:0] op_a;
  logic [WORD_W*NWORDS-1:0] op_b;
  logic                     cin;
`ifdef MWADD_SUB_EN
  logic                     op_sub;
`endif
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [WORD_W*NWORDS-1:0] rsp_sum;
  logic                     rsp_cout;

  modport master (
`ifdef MWADD_SUB_EN
    output op_sub,
`endif
    output req_valid, op_a, op_b, cin, rsp_ready,
    input  req_ready, rsp_valid, rsp_sum, rsp_cout
  );

  modport slave (
`ifdef MWADD_SUB_EN
    input  op_sub,
`endif
    input  req_valid, op_a, op_b, cin, rsp_ready,
    output req_ready, rsp_valid, rsp_sum, rsp_cout
  );

endinterface

// File: rtl/multiword_add_seq_cla.sv
// 64-bit two-level carry-lookahead adder (4-bit groups, 16-bit blocks) with group
// propagate/generate outputs for cascading.
module CLA_64bit
  import multiword_add_seq_pkg::*;
(
  input  word_t a,
  input  word_t b,
  input  logic  cin,
  output word_t sum,
  output logic  cout,
  output logic  pg,
  output logic  gg
);

   word_t       p;
   word_t       g;
   word_t       c;
   logic [15:0] p1;
   logic [15:0] g1;
   logic [15:0] c1;
   logic [3:0]  p2;
   logic [3:0]  g2;
   logic [4:0]  c2;

   always_comb begin
      p = a ^ b;
      g = a & b;
      for (int k = 0; k < 16; k++) begin
         {p1[k], g1[k]} = pg4(p[4*k +: 4], g[4*k +: 4]);
      end
      for (int j = 0; j < 4; j++) begin
         {p2[j], g2[j]} = pg4(p1[4*j +: 4], g1[4*j +: 4]);
      end
      // Block carries first, then fan out to groups and bits inside each block.
      c2[0] = cin;
      for (int j = 0; j < 4; j++) begin
         c2[j+1] = g2[j] | (p2[j] & c2[j]);
      end
      for (int k = 0; k < 16; k++) begin
         if (k % 4 == 0) c1[k] = c2[k/4];
         else            c1[k] = g1[k-1] | (p1[k-1] & c1[k-1]);
      end
      for (int i = 0; i < 64; i++) begin
         if (i % 4 == 0) c[i] = c1[i/4];
         else            c[i] = g[i-1] | (p[i-1] & c[i-1]);
      end
      sum      = p ^ c;
      cout     = c2[4];
      {pg, gg} = pg4(p2, g2);
   end

endmodule

// File: rtl/multiword_add_seq.sv
// Sequential NWORDS x 64-bit adder: one word per cycle through a shared CLA, valid/ready
// on both sides. Defining MWADD_SUB_EN adds op_sub (A - B via ~B with carry-in forced to 1).
module multiword_add_seq
  import multiword_add_seq_pkg::*;
#(
   parameter int unsigned NWORDS = NWORDS_DEF
) (
   input logic                clk,
   input logic                rst,
   multiword_add_seq_if.slave bus
);

   localparam int unsigned      CNT_W = cnt_width(NWORDS);
   localparam int unsigned      OP_W  = WORD_W * NWORDS;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(NWORDS - 1);

   if (NWORDS < 2 || NWORDS > 8) begin : g_bad_nwords
      $error("multiword_add_seq: NWORDS must be in 2..8");
   end

   logic [1:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic [OP_W-1:0]  a_q, a_d;
   logic [OP_W-1:0]  b_q, b_d;
   logic [OP_W-1:0]  sum_q, sum_d;
   logic             cout_q, cout_d;

   word_t a_word;
   word_t b_word;
   word_t cla_sum;
   logic  cla_cout;
   logic  unused_pg;
   logic  unused_gg;
   logic  init_carry;

`ifdef MWADD_SUB_EN
   logic sub_q, sub_d;

   assign init_carry = bus.op_sub ? 1'b1 : bus.cin;
   assign b_word     = sub_q ? ~b_q[WORD_W*int'(cnt_q) +: WORD_W]
                             :  b_q[WORD_W*int'(cnt_q) +: WORD_W];
`else
   assign init_carry = bus.cin;
   assign b_word     = b_q[WORD_W*int'(cnt_q) +: WORD_W];
`endif

   assign a_word = a_q[WORD_W*int'(cnt_q) +: WORD_W];

   CLA_64bit u_cla (
      .a    (a_word),
      .b    (b_word),
      .cin  (carry_q),
      .sum  (cla_sum),
      .cout (cla_cout),
      .pg   (unused_pg),
      .gg   (unused_gg)
   );

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      cout_d  = cout_q;
`ifdef MWADD_SUB_EN
      sub_d   = sub_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (bus.req_valid) begin
               a_d     = bus.op_a;
               b_d     = bus.op_b;
               cnt_d   = '0;
               carry_d = init_carry;
`ifdef MWADD_SUB_EN
               sub_d   = bus.op_sub;
`endif
               state_d = ST_ADD;
            end
         end
         ST_ADD: begin
            sum_d[WORD_W*int'(cnt_q) +: WORD_W] = cla_sum;
            carry_d = cla_cout;
            // Counter parks on the last word rather than wrapping.
            if (cnt_q == LAST) begin
               cout_d  = cla_cout;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DONE: begin
            if (bus.rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   end

`ifdef MWADD_SUB_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sub_q <= 1'b0;
      else     sub_q <= sub_d;
   end
`endif

   assign bus.req_ready = (state_q == ST_IDLE);
   assign bus.rsp_valid = (state_q == ST_DONE);
   assign bus.rsp_sum   = sum_q;
   assign bus.rsp_cout  = cout_q;

endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed + random bench for multiword_add_seq (NWORDS=4) against a 257-bit arithmetic
// model; subtract cases are added when MWADD_SUB_EN is defined.
module tb_multiword_add_seq;

   localparam int unsigned NW = 4;
   localparam int unsigned W  = 64 * NW;

   logic clk;
   logic rst;
   int   vectors     = 0;
   int   miscompares = 0;

   multiword_add_seq_if #(.NWORDS(NW)) bus ();

   multiword_add_seq #(.NWORDS(NW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] rand_op();
      logic [W-1:0] v;
      for (int i = 0; i < NW * 2; i++) v[32*i +: 32] = $urandom;
      return v;
   endfunction

   // Reference: plain wide arithmetic; subtraction is A + ~B + 1 with cin ignored.
   function automatic logic [W:0] golden(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic c, input logic s);
      if (s) return {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
      return {1'b0, a} + {1'b0, b} + (W+1)'(c);
   endfunction

   task automatic set_sub(input logic s);
`ifdef MWADD_SUB_EN
      bus.op_sub = s;
`else
      if (s) $display("note: subtract requested without MWADD_SUB_EN");
`endif
   endtask

   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input logic s, input int stall);
      logic [W:0] exp;
      int         lat;
      exp = golden(a, b, c, s);
      chk("req_ready_idle", bus.req_ready, 1);
      bus.req_valid = 1'b1;
      bus.op_a      = a;
      bus.op_b      = b;
      bus.cin       = c;
      set_sub(s);
      bus.rsp_ready = 1'b0;
      @(negedge clk);
      // Scramble inputs after the accept edge; they must not disturb the operation.
      bus.req_valid = 1'b0;
      bus.op_a      = rand_op();
      bus.op_b      = rand_op();
      bus.cin       = ~c;
`ifdef MWADD_SUB_EN
      bus.op_sub    = ~s;
`endif
      lat = 0;
      while (!bus.rsp_valid && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      chk("latency", 320'(lat), 320'(NW));
      for (int i = 0; i < stall; i++) begin
         chk("stall_valid", bus.rsp_valid, 1);
         chk("stall_req_ready", bus.req_ready, 0);
         chk("stall_sum", bus.rsp_sum, exp[W-1:0]);
         chk("stall_cout", bus.rsp_cout, exp[W]);
         @(negedge clk);
      end
      chk("sum", bus.rsp_sum, exp[W-1:0]);
      chk("cout", bus.rsp_cout, exp[W]);
      chk("done_req_ready", bus.req_ready, 0);
      // Offer a request in the handshake cycle; it must not be taken.
      bus.rsp_ready = 1'b1;
      bus.req_valid = 1'b1;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      bus.req_valid = 1'b0;
      chk("rsp_valid_drop", bus.rsp_valid, 0);
      chk("req_ready_back", bus.req_ready, 1);
   endtask

   initial begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         c;
      logic         s;

      rst           = 1'b1;
      bus.req_valid = 1'b0;
      bus.op_a      = '0;
      bus.op_b      = '0;
      bus.cin       = 1'b0;
      set_sub(1'b0);
      bus.rsp_ready = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_req_ready", bus.req_ready, 1);
      chk("rst_rsp_valid", bus.rsp_valid, 0);
      chk("rst_rsp_sum", bus.rsp_sum, 0);
      chk("rst_rsp_cout", bus.rsp_cout, 0);
      rst = 1'b0;
      @(negedge clk);

      // All-ones + 0 + cin ripples a carry through every word.
      run_op({W{1'b1}}, '0, 1'b1, 1'b0, 0);
      // Carry out of word 0 lands in word 1.
      run_op(W'(64'hFFFF_FFFF_FFFF_FFFF), W'(1), 1'b0, 1'b0, 0);
      chk("cross_word_expect", golden(W'(64'hFFFF_FFFF_FFFF_FFFF), W'(1), 1'b0, 1'b0),
          (W+1)'(1) << 64);
      // Consumer stalls five cycles in DONE.
      run_op(rand_op(), rand_op(), 1'b1, 1'b0, 5);

      // Reset while word 2 is being added.
      bus.req_valid = 1'b1;
      bus.op_a      = {64'h1111, 64'h2222, 64'h3333, 64'h4444};
      bus.op_b      = {64'h5, 64'h6, 64'h7, 64'h8};
      bus.cin       = 1'b0;
      @(negedge clk);
      bus.req_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("mid_add_busy", bus.req_ready, 0);
      #2 rst = 1'b1;
      #1;
      chk("midrst_rsp_valid", bus.rsp_valid, 0);
      chk("midrst_rsp_sum", bus.rsp_sum, 0);
      chk("midrst_req_ready", bus.req_ready, 1);
      chk("midrst_rsp_cout", bus.rsp_cout, 0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      run_op(W'(3), W'(4), 1'b0, 1'b0, 0);

`ifdef MWADD_SUB_EN
      run_op(W'(5), W'(7), 1'b0, 1'b1, 0);
      chk("sub_5_7_expect", golden(W'(5), W'(7), 1'b0, 1'b1), {1'b0, {(W-1){1'b1}}, 1'b0});
      run_op(W'(7), W'(5), 1'b0, 1'b1, 1);
      chk("sub_7_5_expect", golden(W'(7), W'(5), 1'b1, 1'b1), {1'b1, W'(2)});
`endif

      for (int n = 0; n < 100; n++) begin
         a = rand_op();
         b = ($urandom_range(0, 3) == 0) ? ~a : rand_op();
         c = 1'($urandom);
`ifdef MWADD_SUB_EN
         s = 1'($urandom);
`else
         s = 1'b0;
`endif
         run_op(a, b, c, s, int'($urandom_range(0, 3)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
